fetch_ctrl: RTL and testbench

Sequencer for the fetch stage. It owns the architectural fetch PC and produces the `fetch_stall` and `fetch_bubble` controls that drive the fetch pipeline register and icache. It arbitrates between three event sources: backend back-pressure, branch/exception redirects, and icache miss/refill. It sits between the execute/commit redirect path and the fetch stage.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_perf_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencer.
// Holds the FSM state enum, instruction size and default reset PC.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    KILL = 2'd2
  } fetch_ctrl_state_e;

  localparam logic [63:0] INSTR_BYTES  = 64'd4;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/fetch_ctrl_perf_counter.sv
// perf_counter: free-running event counter, wraps modulo 2^W.
// Ports: i_clk, i_clr (sync clear), i_en (count enable), o_count.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr)
      r_count <= '0;
    else if (i_en)
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner and stall/bubble sequencer.
// Ports: i_clk, i_rst (sync, active-high); backend stall, redirect,
// icache miss/refill inputs; o_pc, o_fetch_stall, o_fetch_bubble,
// and two performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_backend_stall,
  input  logic             i_redirect_valid,
  input  logic [63:0]      i_redirect_pc,
  input  logic             i_icache_miss,
  input  logic             i_icache_refill_done,
  output logic [63:0]      o_pc,
  output logic             o_fetch_stall,
  output logic             o_fetch_bubble,
  output logic [CNT_W-1:0] o_perf_miss_cycles,
  output logic [CNT_W-1:0] o_perf_redirects
);

  fetch_ctrl_state_e r_state;
  fetch_ctrl_state_e w_state_nxt;
  logic [63:0]       r_pc;
  logic [63:0]       w_pc_nxt;
  logic              w_not_run;
  logic              w_unused;

  // Redirect targets are word aligned; the low bits are dropped.
  assign w_unused  = ^i_redirect_pc[1:0];
  assign w_not_run = (r_state != RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  // A refill in flight must be drained even when the line is no
  // longer wanted, so a redirect moves MISS to KILL rather than RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (i_icache_miss)
          w_state_nxt = i_redirect_valid ? KILL : MISS;
      end
      MISS: begin
        if (i_icache_refill_done)
          w_state_nxt = RUN;
        else if (i_redirect_valid)
          w_state_nxt = KILL;
      end
      KILL: begin
        if (i_icache_refill_done)
          w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // A redirect always clears the entry; a miss only clears it when
  // the backend is not holding it.
  always_comb begin
    o_fetch_stall  = i_backend_stall & ~i_redirect_valid;
    o_fetch_bubble = i_redirect_valid |
                     (~i_backend_stall & (w_not_run | i_icache_miss));
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (i_redirect_valid)
      w_pc_nxt = {i_redirect_pc[63:2], 2'b00};
    else if (!w_not_run && !i_icache_miss && !i_backend_stall)
      w_pc_nxt = r_pc + INSTR_BYTES;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_pc <= RESET_PC;
    else
      r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

  perf_counter #(.W(CNT_W)) u_miss_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_en    (w_not_run),
    .o_count (o_perf_miss_cycles)
  );

  perf_counter #(.W(CNT_W)) u_redir_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_en    (i_redirect_valid),
    .o_count (o_perf_redirects)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        bstall;
  logic        rvalid;
  logic [63:0] rpc;
  logic        miss;
  logic        rdone;
  logic [63:0] pc;
  logic        fstall;
  logic        fbubble;
  logic [31:0] pmiss;
  logic [31:0] predir;

  int tests;
  int fails;

  localparam logic [63:0] RPC = 64'h8000_0000;

  fetch_ctrl dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_backend_stall      (bstall),
    .i_redirect_valid     (rvalid),
    .i_redirect_pc        (rpc),
    .i_icache_miss        (miss),
    .i_icache_refill_done (rdone),
    .o_pc                 (pc),
    .o_fetch_stall        (fstall),
    .o_fetch_bubble       (fbubble),
    .o_perf_miss_cycles   (pmiss),
    .o_perf_redirects     (predir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bstall = 1'b0;
    rvalid = 1'b0;
    rpc    = '0;
    miss   = 1'b0;
    rdone  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (pc !== RPC || fstall !== 1'b0 || fbubble !== 1'b0 ||
        pmiss !== 32'd0 || predir !== 32'd0) begin
      fails++;
      $display("FAIL reset: pc=%h st=%b bb=%b pm=%0d pr=%0d",
               pc, fstall, fbubble, pmiss, predir);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (pc !== RPC + 64'(4 * i) || fbubble !== 1'b0) begin
        fails++;
        $display("FAIL seq[%0d]: pc=%h bb=%b want pc=%h bb=0",
                 i, pc, fbubble, RPC + 64'(4 * i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    bstall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (pc !== 64'h8000_0008 || fstall !== 1'b1 ||
          fbubble !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: pc=%h st=%b bb=%b want 8/1/0",
                 i, pc, fstall, fbubble);
      end
      @(negedge clk);
    end
    bstall = 1'b0;
    #1;
    tests++;
    if (pc !== 64'h8000_0008 || fstall !== 1'b0) begin
      fails++;
      $display("FAIL stall_rel: pc=%h st=%b want 8/0", pc, fstall);
    end
    @(negedge clk);
    #1;
    tests++;
    if (pc !== 64'h8000_000C) begin
      fails++;
      $display("FAIL stall_adv: pc=%h want 8000000c", pc);
    end
  endtask

  task automatic test_miss();
    do_reset();
    repeat (4) @(negedge clk);
    miss = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdone = (i == 5);
      #1;
      tests++;
      if (pc !== 64'h8000_0010 || fbubble !== 1'b1) begin
        fails++;
        $display("FAIL miss[%0d]: pc=%h bb=%b want 10/1",
                 i, pc, fbubble);
      end
      @(negedge clk);
      miss = 1'b0;
    end
    rdone = 1'b0;
    #1;
    tests++;
    if (pc !== 64'h8000_0010 || fbubble !== 1'b0 ||
        pmiss !== 32'd5) begin
      fails++;
      $display("FAIL miss_retry: pc=%h bb=%b pm=%0d want 10/0/5",
               pc, fbubble, pmiss);
    end
    @(negedge clk);
    #1;
    tests++;
    if (pc !== 64'h8000_0014) begin
      fails++;
      $display("FAIL miss_adv: pc=%h want 80000014", pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bstall = 1'b1;
    rvalid = 1'b1;
    rpc    = 64'h8000_1003;
    #1;
    tests++;
    if (fbubble !== 1'b1 || fstall !== 1'b0) begin
      fails++;
      $display("FAIL redir_ctl: bb=%b st=%b want 1/0",
               fbubble, fstall);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (pc !== 64'h8000_1000 || predir !== 32'd1) begin
      fails++;
      $display("FAIL redir_pc: pc=%h pr=%0d want 80001000/1",
               pc, predir);
    end
    @(negedge clk);
    #1;
    tests++;
    if (pc !== 64'h8000_1004) begin
      fails++;
      $display("FAIL redir_adv: pc=%h want 80001004", pc);
    end
  endtask

  task automatic test_miss_kill();
    logic [63:0] epc;
    logic        ebb;
    do_reset();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      idle();
      miss   = (i == 0);
      rvalid = (i == 2) || (i == 4);
      rpc    = (i == 4) ? 64'h8000_3000 : 64'h8000_2000;
      rdone  = (i == 5);
      epc = (i < 3) ? 64'h8000_0020 :
            (i < 5) ? 64'h8000_2000 :
            (i < 7) ? 64'h8000_2000 : 64'h8000_2004;
      if (i == 5) epc = 64'h8000_3000;
      if (i == 6) epc = 64'h8000_3000;
      if (i == 7) epc = 64'h8000_3004;
      ebb = (i < 6);
      #1;
      tests++;
      if (pc !== epc || fbubble !== ebb) begin
        fails++;
        $display("FAIL kill[%0d]: pc=%h bb=%b want %h/%b",
                 i, pc, fbubble, epc, ebb);
      end
      if (i == 6) begin
        tests++;
        if (pmiss !== 32'd5 || predir !== 32'd2) begin
          fails++;
          $display("FAIL kill_cnt: pm=%0d pr=%0d want 5/2",
                   pmiss, predir);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_refill();
    do_reset();
    miss = 1'b1;
    @(negedge clk);
    idle();
    rvalid = 1'b1;
    rdone  = 1'b1;
    rpc    = 64'h8000_4000;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (pc !== 64'h8000_4000 || fbubble !== 1'b0) begin
      fails++;
      $display("FAIL rr_same: pc=%h bb=%b want 80004000/0",
               pc, fbubble);
    end
    @(negedge clk);
    #1;
    tests++;
    if (pc !== 64'h8000_4004) begin
      fails++;
      $display("FAIL rr_adv: pc=%h want 80004004", pc);
    end
  endtask

  task automatic test_reset_mid_refill();
    do_reset();
    miss = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (fbubble !== 1'b0 || pc !== RPC || pmiss !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid: bb=%b pc=%h pm=%0d want 0/%h/0",
               fbubble, pc, pmiss, RPC);
    end
    @(negedge clk);
    #1;
    tests++;
    if (pc !== RPC + 64'd4) begin
      fails++;
      $display("FAIL rst_mid_adv: pc=%h want 80000004", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rvalid = 1'b1;
    rpc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e;
      e = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'(4 * (i - 1));
      #1;
      tests++;
      if (pc !== e) begin
        fails++;
        $display("FAIL wrap[%0d]: pc=%h want %h", i, pc, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle();
    test_reset();
    test_stall();
    test_miss();
    test_redirect();
    test_miss_kill();
    test_redirect_refill();
    test_reset_mid_refill();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
